// File: rtl/region_probe.sv
// Scans a size x size square of pixel memory through a synchronous read port and
// reports the first non-background pixel in column-major, descending-offset order.
module region_probe #(
    parameter int                 COORD_W    = 10,
    parameter int                 COLOR_W    = 3,
    parameter logic [COLOR_W-1:0] BG_COLOR   = '0,
    parameter int                 EARLY_EXIT = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [COORD_W-1:0] size,
    output logic               rd_en,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    input  logic [COLOR_W-1:0] rd_color,
    output logic               busy,
    output logic               done,
    output logic               hit,
    output logic [COORD_W-1:0] hit_x,
    output logic [COORD_W-1:0] hit_y,
    output logic [COLOR_W-1:0] hit_color
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, y_q, size_q;
    logic [COORD_W-1:0] qx_q, qx_d, qy_q, qy_d;
    logic               vld_q;
    logic [COORD_W-1:0] dx_q, dy_q;
    logic               hit_q;
    logic [COORD_W-1:0] hit_x_q, hit_y_q;
    logic [COLOR_W-1:0] hit_color_q;
    logic [COORD_W-1:0] addr_x, addr_y;
    logic               capture;

    assign addr_x  = x_q + qx_q;
    assign addr_y  = y_q + qy_q;
    // Data returned this cycle belongs to the address issued one cycle earlier.
    assign capture = vld_q && (rd_color != BG_COLOR) && !hit_q;

    always_comb begin
        state_d = state_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        rd_en   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    qx_d    = size - 1'b1;
                    qy_d    = size - 1'b1;
                    state_d = (size == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (qy_q == '0) begin
                    qy_d = size_q - 1'b1;
                    qx_d = qx_q - 1'b1;
                end else begin
                    qy_d = qy_q - 1'b1;
                end
                if ((EARLY_EXIT != 0) && capture) begin
                    state_d = DONE;
                end else if ((qx_q == '0) && (qy_q == '0)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            size_q      <= '0;
            qx_q        <= '0;
            qy_q        <= '0;
            vld_q       <= 1'b0;
            dx_q        <= '0;
            dy_q        <= '0;
            hit_q       <= 1'b0;
            hit_x_q     <= '0;
            hit_y_q     <= '0;
            hit_color_q <= '0;
        end else begin
            state_q <= state_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            // A read issued in the early-exit cycle is never compared.
            vld_q   <= rd_en && (state_d != DONE);
            if (rd_en) begin
                dx_q <= addr_x;
                dy_q <= addr_y;
            end
            if ((state_q == IDLE) && start) begin
                x_q         <= x_in;
                y_q         <= y_in;
                size_q      <= size;
                hit_q       <= 1'b0;
                hit_x_q     <= '0;
                hit_y_q     <= '0;
                hit_color_q <= '0;
            end else if (capture) begin
                hit_q       <= 1'b1;
                hit_x_q     <= dx_q;
                hit_y_q     <= dy_q;
                hit_color_q <= rd_color;
            end
        end
    end

    assign rd_x      = rd_en ? addr_x : '0;
    assign rd_y      = rd_en ? addr_y : '0;
    assign hit       = hit_q;
    assign hit_x     = hit_x_q;
    assign hit_y     = hit_y_q;
    assign hit_color = hit_color_q;

endmodule

// File: tb/tb_region_probe.sv
// Scoreboard bench for region_probe: an early-exit and a full-scan instance share one
// sparse pixel memory; expectations come from a plain loop over the square.
module tb_region_probe;

    typedef struct {
        logic [9:0] ax;
        logic [9:0] ay;
        int         cyc;
    } addr_t;

    typedef struct {
        logic       hit;
        logic [9:0] hx;
        logic [9:0] hy;
        logic [2:0] hc;
        int         cyc;
    } res_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [9:0] xIn = '0, yIn = '0, sizeIn = '0;

    logic       rdEn [2];
    logic [9:0] rdX [2];
    logic [9:0] rdY [2];
    logic [2:0] rdColor [2];
    logic       busy [2];
    logic       done [2];
    logic       hit [2];
    logic [9:0] hitX [2];
    logic [9:0] hitY [2];
    logic [2:0] hitColor [2];

    logic [2:0] mem [int];
    addr_t      addrQ [2][$];
    res_t       resQ [2][$];
    res_t       lastRes [2];
    int         readsSeen [2];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    region_probe #(.COORD_W(10), .COLOR_W(3), .BG_COLOR(3'b000), .EARLY_EXIT(1)) uEarly (
        .clk(clk), .resetn(resetn), .start(start), .x_in(xIn), .y_in(yIn), .size(sizeIn),
        .rd_en(rdEn[0]), .rd_x(rdX[0]), .rd_y(rdY[0]), .rd_color(rdColor[0]),
        .busy(busy[0]), .done(done[0]), .hit(hit[0]), .hit_x(hitX[0]), .hit_y(hitY[0]),
        .hit_color(hitColor[0]));

    region_probe #(.COORD_W(10), .COLOR_W(3), .BG_COLOR(3'b000), .EARLY_EXIT(0)) uFull (
        .clk(clk), .resetn(resetn), .start(start), .x_in(xIn), .y_in(yIn), .size(sizeIn),
        .rd_en(rdEn[1]), .rd_x(rdX[1]), .rd_y(rdY[1]), .rd_color(rdColor[1]),
        .busy(busy[1]), .done(done[1]), .hit(hit[1]), .hit_x(hitX[1]), .hit_y(hitY[1]),
        .hit_color(hitColor[1]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int keyOf(input int px, input int py);
        return ((px % 1024) * 1024) + (py % 1024);
    endfunction

    function automatic logic [2:0] peek(input int px, input int py);
        int k = keyOf(px, py);
        return mem.exists(k) ? mem[k] : 3'b000;
    endfunction

    // Synchronous pixel memory: data appears one cycle after the strobe.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rdEn[d]) rdColor[d] <= peek(int'(rdX[d]), int'(rdY[d]));
        end
    end

    task automatic checkOutput(input string name, input int d, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    task automatic reportFail(input string name, input int d);
        tests++;
        fails++;
        $display("[TB] FAIL %s dut%0d: unexpected event at cycle %0d", name, d, cyc);
    endtask

    addr_t monA;
    res_t  monR;

    always @(negedge clk) begin
        if (resetn) begin
            for (int d = 0; d < 2; d++) begin
                if (rdEn[d]) begin
                    if (addrQ[d].size() == 0) begin
                        reportFail("extra_read", d);
                    end else begin
                        monA = addrQ[d].pop_front();
                        readsSeen[d]++;
                        checkOutput("rd_x", d, rdX[d], monA.ax);
                        checkOutput("rd_y", d, rdY[d], monA.ay);
                        checkOutput("rd_cycle", d, cyc, monA.cyc);
                    end
                end
                if (done[d]) begin
                    if (resQ[d].size() == 0) begin
                        reportFail("extra_done", d);
                    end else begin
                        monR = resQ[d].pop_front();
                        checkOutput("done_cycle", d, cyc, monR.cyc);
                        checkOutput("missing_reads", d, addrQ[d].size(), 0);
                        checkOutput("hit", d, hit[d], monR.hit);
                        checkOutput("hit_x", d, hitX[d], monR.hx);
                        checkOutput("hit_y", d, hitY[d], monR.hy);
                        checkOutput("hit_color", d, hitColor[d], monR.hc);
                    end
                end
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((busy[0] || busy[1] || done[0] || done[1]) && n < 300);
        if (n >= 300) reportFail("idle_timeout", 0);
    endtask

    // Walks the square in scan order and queues every read and the final result.
    task automatic buildExpect(input logic [9:0] x, input logic [9:0] y, input logic [9:0] s, input int c);
        addr_t list[$];
        addr_t a;
        res_t  r;
        int    k = 0;
        int    n;
        int    reads;
        r = '{hit: 1'b0, hx: '0, hy: '0, hc: '0, cyc: 0};
        for (int qx = int'(s) - 1; qx >= 0; qx--) begin
            for (int qy = int'(s) - 1; qy >= 0; qy--) begin
                a.ax  = 10'((int'(x) + qx) % 1024);
                a.ay  = 10'((int'(y) + qy) % 1024);
                a.cyc = c + list.size() + 1;
                list.push_back(a);
                if (k == 0 && peek(int'(a.ax), int'(a.ay)) != 3'b000) begin
                    k     = list.size();
                    r.hit = 1'b1;
                    r.hx  = a.ax;
                    r.hy  = a.ay;
                    r.hc  = peek(int'(a.ax), int'(a.ay));
                end
            end
        end
        n = int'(s) * int'(s);
        for (int d = 0; d < 2; d++) begin
            if (n == 0) begin
                reads = 0;
                r.cyc = c + 1;
            end else if (d == 0 && k > 0) begin
                reads = (k + 1 < n) ? k + 1 : n;
                r.cyc = c + k + 2;
            end else begin
                reads = n;
                r.cyc = c + n + 2;
            end
            for (int i = 0; i < reads; i++) addrQ[d].push_back(list[i]);
            resQ[d].push_back(r);
            lastRes[d]   = r;
            readsSeen[d] = 0;
        end
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic [9:0] s);
        waitIdle();
        for (int d = 0; d < 2; d++) begin
            checkOutput("hold_hit", d, hit[d], lastRes[d].hit);
            checkOutput("hold_hit_x", d, hitX[d], lastRes[d].hx);
            checkOutput("hold_hit_y", d, hitY[d], lastRes[d].hy);
            checkOutput("hold_color", d, hitColor[d], lastRes[d].hc);
        end
        buildExpect(x, y, s, cyc);
        xIn    = x;
        yIn    = y;
        sizeIn = s;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        xIn    = $urandom;
        yIn    = $urandom;
        sizeIn = $urandom;
    endtask

    task automatic setPixel(input int px, input int py, input logic [2:0] c);
        mem[keyOf(px, py)] = c;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) lastRes[d] = '{hit: 1'b0, hx: '0, hy: '0, hc: '0, cyc: 0};
        #23;
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset_rd_en", d, rdEn[d], 0);
            checkOutput("reset_busy", d, busy[d], 0);
            checkOutput("reset_done", d, done[d], 0);
            checkOutput("reset_hit", d, hit[d], 0);
        end
        @(negedge clk);
        resetn = 1'b1;

        // Directed cases: empty square, single hit, two hits, last-pixel hit.
        applyStimulus(10'd100, 10'd50, 10'd4);
        waitIdle();
        mem.delete();
        setPixel(101, 52, 3'b111);
        applyStimulus(10'd100, 10'd50, 10'd4);
        waitIdle();
        mem.delete();
        setPixel(102, 51, 3'b100);
        setPixel(100, 53, 3'b010);
        applyStimulus(10'd100, 10'd50, 10'd4);
        waitIdle();
        mem.delete();
        setPixel(100, 50, 3'b001);
        applyStimulus(10'd100, 10'd50, 10'd4);

        applyStimulus(10'd100, 10'd50, 10'd0);
        waitIdle();
        mem.delete();
        // A start pulse while busy must not disturb the scan already queued.
        applyStimulus(10'd100, 10'd50, 10'd4);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("busy_at_pulse", 0, busy[0], 1);
        xIn    = 10'd7;
        yIn    = 10'd9;
        sizeIn = 10'd2;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;

        for (int t = 0; t < 40; t++) begin
            logic [9:0] rx, ry, rs;
            int         np;
            waitIdle();
            mem.delete();
            rs = 10'($urandom_range(0, 6));
            rx = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1018, 1023)) : 10'($urandom);
            ry = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1018, 1023)) : 10'($urandom);
            np = $urandom_range(0, 3);
            for (int p = 0; p < np && rs != 0; p++) begin
                setPixel(int'(rx) + $urandom_range(0, int'(rs) - 1),
                         int'(ry) + $urandom_range(0, int'(rs) - 1),
                         3'($urandom_range(1, 7)));
            end
            setPixel($urandom_range(0, 1023), $urandom_range(0, 1023), 3'($urandom_range(1, 7)));
            applyStimulus(rx, ry, rs);
        end

        // Wrapping scan aborted by reset on its fifth read.
        waitIdle();
        mem.delete();
        applyStimulus(10'd1022, 10'd1020, 10'd4);
        for (int i = 0; i < 20 && readsSeen[0] < 5; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("reads_before_reset", 0, readsSeen[0], 5);
        resetn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("abort_rd_en", d, rdEn[d], 0);
            checkOutput("abort_busy", d, busy[d], 0);
            checkOutput("abort_done", d, done[d], 0);
            checkOutput("abort_hit", d, hit[d], 0);
            addrQ[d].delete();
            resQ[d].delete();
            lastRes[d] = '{hit: 1'b0, hx: '0, hy: '0, hc: '0, cyc: 0};
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (25) @(posedge clk);
        #1;

        mem.delete();
        setPixel(1, 2, 3'b011);
        applyStimulus(10'd1023, 10'd1022, 10'd3);
        waitIdle();
        for (int d = 0; d < 2; d++) begin
            checkOutput("pending_reads", d, addrQ[d].size(), 0);
            checkOutput("pending_results", d, resQ[d].size(), 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
